// File: rtl/sn_net_cmd_sequencer_if.sv
// Command, network-control and response signals of the command sequencer.
// master = sequencer side, slave = host/network side.
interface sn_net_cmd_sequencer_if #(
   parameter int P_NUM_NEURONS     = 21,
   parameter int P_TABLE_NUM_ROWS  = 4,
   parameter int P_NEUR_CURRENT_BW = 9,
   parameter int P_MAX_NUM_PERIODS = 2000,
   parameter int P_WDOG_BW         = 16
);
   localparam int L_MSB_BW = $clog2(P_NUM_NEURONS + 1);
   localparam int L_LSB_BW = $clog2(P_TABLE_NUM_ROWS * 2 + 2);
   localparam int L_PER_BW = $clog2(P_MAX_NUM_PERIODS + 1);

   logic                          cmd_valid;
   logic                          cmd_ready;
   logic [1:0]                    cmd_op;
   logic [L_MSB_BW-1:0]           cmd_neuron;
   logic [L_LSB_BW-1:0]           cmd_sub;
   logic [L_MSB_BW-1:0]           cmd_aux;
   logic [P_WDOG_BW-1:0]          cmd_data;
   logic                          abort;
   logic                          net_we;
   logic [L_MSB_BW+L_LSB_BW-1:0]  net_waddr;
   logic [P_NEUR_CURRENT_BW-1:0]  net_wdata;
   logic                          net_num_per_wen;
   logic [L_PER_BW-1:0]           net_num_per_d;
   logic                          net_start;
   logic                          net_done;
   logic                          rsp_valid;
   logic                          rsp_timeout;
   logic [P_WDOG_BW-1:0]          rsp_cycles;
   logic                          err_cmd;
   logic                          busy;

   modport master (
      input  cmd_valid, cmd_op, cmd_neuron, cmd_sub, cmd_aux, cmd_data, abort, net_done,
      output cmd_ready, net_we, net_waddr, net_wdata, net_num_per_wen, net_num_per_d,
             net_start, rsp_valid, rsp_timeout, rsp_cycles, err_cmd, busy
   );

   modport slave (
      output cmd_valid, cmd_op, cmd_neuron, cmd_sub, cmd_aux, cmd_data, abort, net_done,
      input  cmd_ready, net_we, net_waddr, net_wdata, net_num_per_wen, net_num_per_d,
             net_start, rsp_valid, rsp_timeout, rsp_cycles, err_cmd, busy
   );
endinterface

// File: rtl/sn_net_cmd_sequencer.sv
// Runs one spiking-neuron network from a command stream: memory/weight writes, period setup,
// start and watchdog-guarded wait. Strobes are registered; one command in flight (ready only in IDLE).
module sn_net_cmd_sequencer #(
   parameter int P_NUM_NEURONS     = 21,
   parameter int P_TABLE_NUM_ROWS  = 4,
   parameter int P_NEUR_CURRENT_BW = 9,
   parameter int P_MAX_NUM_PERIODS = 2000,
   parameter int P_WDOG_BW         = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   sn_net_cmd_sequencer_if.master    bus
);
   localparam int L_MSB_BW  = $clog2(P_NUM_NEURONS + 1);
   localparam int L_LSB_BW  = $clog2(P_TABLE_NUM_ROWS * 2 + 2);
   localparam int L_PER_BW  = $clog2(P_MAX_NUM_PERIODS + 1);
   localparam int L_ADDR_BW = L_MSB_BW + L_LSB_BW;

   localparam logic [1:0] L_OP_WRITE = 2'd0;
   localparam logic [1:0] L_OP_LOAD  = 2'd1;
   localparam logic [1:0] L_OP_SETP  = 2'd2;

   localparam logic [L_MSB_BW-1:0]  L_NEUR_MAX = L_MSB_BW'(P_NUM_NEURONS);
   localparam logic [L_LSB_BW-1:0]  L_ROWS     = L_LSB_BW'(P_TABLE_NUM_ROWS);
   localparam logic [P_WDOG_BW-1:0] L_PER_MAX  = P_WDOG_BW'(P_MAX_NUM_PERIODS);

   typedef enum logic [2:0] {
      S_IDLE, S_WR, S_WT_IDX, S_WT_VAL, S_SETP, S_START, S_WAIT, S_RSP
   } state_t;

   state_t                        r_state, w_state_nxt;
   logic [L_MSB_BW-1:0]           r_neuron;
   logic [L_LSB_BW-2:0]           r_row;
   logic [P_WDOG_BW-1:0]          r_data;
   logic [P_WDOG_BW-1:0]          r_cnt;
   logic                          r_net_we, r_per_wen, r_start, r_rsp_valid, r_rsp_timeout, r_err;
   logic [L_ADDR_BW-1:0]          r_net_waddr;
   logic [P_NEUR_CURRENT_BW-1:0]  r_net_wdata;
   logic [L_PER_BW-1:0]           r_per_d;
   logic [P_WDOG_BW-1:0]          r_rsp_cycles;

   logic                          w_accept, w_neur_ok, w_aux_ok, w_row_ok, w_per_ok, w_cmd_legal;
   logic                          w_err_set, w_we, w_per_wen, w_start, w_rsp_valid, w_rsp_timeout;
   logic [L_ADDR_BW-1:0]          w_waddr;
   logic [P_NEUR_CURRENT_BW-1:0]  w_wdata;
   logic [L_PER_BW-1:0]           w_per_d;
   logic [P_WDOG_BW-1:0]          w_rsp_cycles;
   logic [L_LSB_BW-1:0]           w_idx_sub, w_val_sub;
   logic                          w_wdog_hit;

   assign w_accept  = bus.cmd_valid && (r_state == S_IDLE);
   assign w_neur_ok = (bus.cmd_neuron != '0) && (bus.cmd_neuron <= L_NEUR_MAX);
   assign w_aux_ok  = (bus.cmd_aux != '0) && (bus.cmd_aux <= L_NEUR_MAX);
   assign w_row_ok  = bus.cmd_sub < L_ROWS;
   assign w_per_ok  = (bus.cmd_data != '0) && (bus.cmd_data <= L_PER_MAX);
   // Weight row r occupies the index/value pair at internal addresses 2r+2 and 2r+3.
   assign w_idx_sub  = {bus.cmd_sub[L_LSB_BW-2:0], 1'b0} + L_LSB_BW'(2);
   assign w_val_sub  = {r_row, 1'b0} + L_LSB_BW'(3);
   assign w_wdog_hit = (r_data != '0) && (r_cnt == r_data);

   always_comb begin
      w_cmd_legal = 1'b1;
      case (bus.cmd_op)
         L_OP_WRITE: w_cmd_legal = w_neur_ok;
         L_OP_LOAD:  w_cmd_legal = w_neur_ok && w_row_ok && w_aux_ok;
         L_OP_SETP:  w_cmd_legal = w_per_ok;
         default:    w_cmd_legal = 1'b1;
      endcase
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_err_set     = 1'b0;
      w_we          = 1'b0;
      w_waddr       = '0;
      w_wdata       = '0;
      w_per_wen     = 1'b0;
      w_per_d       = '0;
      w_start       = 1'b0;
      w_rsp_valid   = 1'b0;
      w_rsp_timeout = r_rsp_timeout;
      w_rsp_cycles  = r_rsp_cycles;
      case (r_state)
         S_IDLE: begin
            if (bus.cmd_valid) begin
               if (!w_cmd_legal) begin
                  w_err_set = 1'b1;
               end else begin
                  case (bus.cmd_op)
                     L_OP_WRITE: begin
                        w_state_nxt = S_WR;
                        w_we        = 1'b1;
                        w_waddr     = {bus.cmd_neuron, bus.cmd_sub};
                        w_wdata     = bus.cmd_data[P_NEUR_CURRENT_BW-1:0];
                     end
                     L_OP_LOAD: begin
                        w_state_nxt = S_WT_IDX;
                        w_we        = 1'b1;
                        w_waddr     = {bus.cmd_neuron, w_idx_sub};
                        w_wdata     = P_NEUR_CURRENT_BW'(bus.cmd_aux);
                     end
                     L_OP_SETP: begin
                        w_state_nxt = S_SETP;
                        w_per_wen   = 1'b1;
                        w_per_d     = bus.cmd_data[L_PER_BW-1:0];
                     end
                     default: begin
                        w_state_nxt = S_START;
                        w_start     = 1'b1;
                     end
                  endcase
               end
            end
         end
         S_WT_IDX: begin
            w_state_nxt = S_WT_VAL;
            w_we        = 1'b1;
            w_waddr     = {r_neuron, w_val_sub};
            w_wdata     = r_data[P_NEUR_CURRENT_BW-1:0];
         end
         S_START: w_state_nxt = S_WAIT;
         S_WAIT: begin
            // Completion takes priority over a same-cycle watchdog hit or abort.
            if (bus.net_done || w_wdog_hit || bus.abort) begin
               w_state_nxt   = S_RSP;
               w_rsp_valid   = 1'b1;
               w_rsp_timeout = !bus.net_done;
               w_rsp_cycles  = r_cnt;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state       <= S_IDLE;
         r_neuron      <= '0;
         r_row         <= '0;
         r_data        <= '0;
         r_cnt         <= '0;
         r_net_we      <= 1'b0;
         r_net_waddr   <= '0;
         r_net_wdata   <= '0;
         r_per_wen     <= 1'b0;
         r_per_d       <= '0;
         r_start       <= 1'b0;
         r_rsp_valid   <= 1'b0;
         r_rsp_timeout <= 1'b0;
         r_rsp_cycles  <= '0;
         r_err         <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_net_we      <= w_we;
         r_net_waddr   <= w_waddr;
         r_net_wdata   <= w_wdata;
         r_per_wen     <= w_per_wen;
         r_per_d       <= w_per_d;
         r_start       <= w_start;
         r_rsp_valid   <= w_rsp_valid;
         r_rsp_timeout <= w_rsp_timeout;
         r_rsp_cycles  <= w_rsp_cycles;
         if (w_err_set) begin
            r_err <= 1'b1;
         end
         if (w_accept) begin
            r_neuron <= bus.cmd_neuron;
            r_row    <= bus.cmd_sub[L_LSB_BW-2:0];
            r_data   <= bus.cmd_data;
         end
         if (r_state == S_START) begin
            r_cnt <= P_WDOG_BW'(1);
         end else if ((r_state == S_WAIT) && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign bus.cmd_ready       = (r_state == S_IDLE);
   assign bus.busy            = (r_state != S_IDLE);
   assign bus.net_we          = r_net_we;
   assign bus.net_waddr       = r_net_waddr;
   assign bus.net_wdata       = r_net_wdata;
   assign bus.net_num_per_wen = r_per_wen;
   assign bus.net_num_per_d   = r_per_d;
   assign bus.net_start       = r_start;
   assign bus.rsp_valid       = r_rsp_valid;
   assign bus.rsp_timeout     = r_rsp_timeout;
   assign bus.rsp_cycles      = r_rsp_cycles;
   assign bus.err_cmd         = r_err;
endmodule

// File: tb/tb_sn_net_cmd_sequencer.sv
// Scoreboard bench for sn_net_cmd_sequencer: directed scenarios then randomized commands,
// expected strobes/responses derived from the command rules and compared by a negedge monitor.
module tb_sn_net_cmd_sequencer;
   localparam int P_NUM_NEURONS     = 21;
   localparam int P_TABLE_NUM_ROWS  = 4;
   localparam int P_NEUR_CURRENT_BW = 9;
   localparam int P_MAX_NUM_PERIODS = 2000;
   localparam int P_WDOG_BW         = 16;
   localparam int L_LSB_BW          = $clog2(P_TABLE_NUM_ROWS * 2 + 2);

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   sn_net_cmd_sequencer_if #(
      .P_NUM_NEURONS(P_NUM_NEURONS), .P_TABLE_NUM_ROWS(P_TABLE_NUM_ROWS),
      .P_NEUR_CURRENT_BW(P_NEUR_CURRENT_BW), .P_MAX_NUM_PERIODS(P_MAX_NUM_PERIODS),
      .P_WDOG_BW(P_WDOG_BW)
   ) bus ();

   sn_net_cmd_sequencer #(
      .P_NUM_NEURONS(P_NUM_NEURONS), .P_TABLE_NUM_ROWS(P_TABLE_NUM_ROWS),
      .P_NEUR_CURRENT_BW(P_NEUR_CURRENT_BW), .P_MAX_NUM_PERIODS(P_MAX_NUM_PERIODS),
      .P_WDOG_BW(P_WDOG_BW)
   ) dut (
      .clk (clk),
      .rst (rst_n),
      .bus (bus)
   );

   // kind: 0 = memory write, 1 = period write, 2 = start
   typedef struct packed {
      logic [1:0]  kind;
      logic [31:0] addr;
      logic [31:0] data;
   } net_ev_t;
   typedef struct packed {
      logic        to;
      logic [31:0] cyc;
   } rsp_t;

   net_ev_t net_q[$];
   rsp_t    rsp_q[$];
   int      vectors = 0;
   int      miscompares = 0;
   bit      model_err = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic note_fail(input string name);
      vectors++;
      miscompares++;
      $display("FAIL %s (t=%0t)", name, $time);
   endtask

   task automatic pop_net(input logic [1:0] k, input logic [31:0] a, input logic [31:0] d);
      net_ev_t e;
      if (net_q.size() == 0) begin
         note_fail($sformatf("net_unexpected_strobe kind=%0d addr=%0d data=%0d, expected none", k, a, d));
      end else begin
         e = net_q.pop_front();
         chk("net_kind", 32'(k), 32'(e.kind));
         chk("net_addr", a, e.addr);
         chk("net_data", d, e.data);
      end
   endtask

   // Monitor: every strobe and response is matched against the scoreboard.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (bus.net_we) pop_net(2'd0, 32'(bus.net_waddr), 32'(bus.net_wdata));
         else begin
            chk("waddr_zero_when_idle", 32'(bus.net_waddr), 32'd0);
            chk("wdata_zero_when_idle", 32'(bus.net_wdata), 32'd0);
         end
         if (bus.net_num_per_wen) pop_net(2'd1, 32'd0, 32'(bus.net_num_per_d));
         else chk("per_d_zero_when_idle", 32'(bus.net_num_per_d), 32'd0);
         if (bus.net_start) pop_net(2'd2, 32'd0, 32'd0);
         if (bus.rsp_valid) begin
            if (rsp_q.size() == 0) begin
               note_fail($sformatf("rsp_unexpected timeout=%0d cycles=%0d, expected none",
                                   bus.rsp_timeout, bus.rsp_cycles));
            end else begin
               rsp_t r;
               r = rsp_q.pop_front();
               chk("rsp_timeout", 32'(bus.rsp_timeout), 32'(r.to));
               chk("rsp_cycles", 32'(bus.rsp_cycles), r.cyc);
            end
         end
      end
   end

   // Reference rules: legality and expected network writes of one command.
   task automatic model_cmd(input int op, input int neuron, input int sub, input int aux, input int data);
      bit nok;
      nok = (neuron >= 1) && (neuron <= P_NUM_NEURONS);
      case (op)
         0: if (nok) net_q.push_back('{2'd0, 32'(neuron * (1 << L_LSB_BW) + sub), 32'(data & 511)});
            else model_err = 1'b1;
         1: if (nok && sub < P_TABLE_NUM_ROWS && aux >= 1 && aux <= P_NUM_NEURONS) begin
               net_q.push_back('{2'd0, 32'(neuron * (1 << L_LSB_BW) + sub * 2 + 2), 32'(aux)});
               net_q.push_back('{2'd0, 32'(neuron * (1 << L_LSB_BW) + sub * 2 + 3), 32'(data & 511)});
            end else model_err = 1'b1;
         2: if (data >= 1 && data <= P_MAX_NUM_PERIODS) net_q.push_back('{2'd1, 32'd0, 32'(data)});
            else model_err = 1'b1;
         default: net_q.push_back('{2'd2, 32'd0, 32'd0});
      endcase
   endtask

   // Returns one time unit after the accepting clock edge.
   task automatic issue(input int op, input int neuron, input int sub, input int aux, input int data);
      int w;
      @(negedge clk);
      bus.cmd_valid  = 1'b1;
      bus.cmd_op     = 2'(op);
      bus.cmd_neuron = 5'(neuron);
      bus.cmd_sub    = 4'(sub);
      bus.cmd_aux    = 5'(aux);
      bus.cmd_data   = 16'(data);
      w = 0;
      while (!bus.cmd_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (w >= 50) note_fail("cmd_accept_timeout");
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int w;
      w = 0;
      while ((net_q.size() != 0 || rsp_q.size() != 0) && w < 100) begin
         @(negedge clk);
         w++;
      end
      if (w >= 100) note_fail($sformatf("drain_timeout net_pending=%0d rsp_pending=%0d", net_q.size(), rsp_q.size()));
   endtask

   task automatic do_cmd(input int op, input int neuron, input int sub, input int aux, input int data);
      model_cmd(op, neuron, sub, aux, data);
      issue(op, neuron, sub, aux, data);
      @(negedge clk);
      chk("err_cmd", 32'(bus.err_cmd), 32'(model_err));
   endtask

   // d/a: cycle after net_start on which net_done/abort pulse; 0 = never.
   task automatic do_run(input int limit, input int d, input int a);
      int best;
      bit to;
      best = 0;
      if (d > 0) best = d;
      if (limit > 0 && (best == 0 || limit < best)) best = limit;
      if (a > 0 && (best == 0 || a < best)) best = a;
      to = !(d > 0 && d == best);
      model_cmd(3, 0, 0, 0, limit);
      rsp_q.push_back('{to, 32'(best)});
      issue(3, 0, 0, 0, limit);
      for (int c = 1; c <= best + 1; c++) begin
         @(posedge clk);
         #1;
         bus.net_done = (c == d);
         bus.abort    = (c == a);
      end
      @(posedge clk);
      #1;
      bus.net_done = 1'b0;
      bus.abort    = 1'b0;
      wait_drain();
      chk("err_cmd_after_run", 32'(bus.err_cmd), 32'(model_err));
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
      chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
      chk({tag, "_net_we"}, 32'(bus.net_we), 32'd0);
      chk({tag, "_net_waddr"}, 32'(bus.net_waddr), 32'd0);
      chk({tag, "_net_wdata"}, 32'(bus.net_wdata), 32'd0);
      chk({tag, "_per_wen"}, 32'(bus.net_num_per_wen), 32'd0);
      chk({tag, "_per_d"}, 32'(bus.net_num_per_d), 32'd0);
      chk({tag, "_net_start"}, 32'(bus.net_start), 32'd0);
      chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
      chk({tag, "_rsp_timeout"}, 32'(bus.rsp_timeout), 32'd0);
      chk({tag, "_rsp_cycles"}, 32'(bus.rsp_cycles), 32'd0);
      chk({tag, "_err_cmd"}, 32'(bus.err_cmd), 32'd0);
   endtask

   initial begin
      #900000;
      $display("FAIL global_time_limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      int op, nrn, sub, aux, dat, lim, d, a;
      bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_neuron = '0; bus.cmd_sub = '0;
      bus.cmd_aux = '0; bus.cmd_data = '0; bus.abort = 1'b0; bus.net_done = 1'b0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1 chk_reset_outputs("reset");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // WRITE with single-cycle busy window
      model_cmd(0, 11, 1, 0, 120);
      issue(0, 11, 1, 0, 120);
      @(negedge clk);
      chk("ready_low_after_write", 32'(bus.cmd_ready), 32'd0);
      @(negedge clk);
      chk("ready_back_after_write", 32'(bus.cmd_ready), 32'd1);

      do_cmd(1, 13, 1, 11, -20);
      do_cmd(2, 0, 0, 0, 1500);
      do_run(10000, 37, 0);
      do_run(50, 0, 0);
      do_run(50, 50, 0);

      // done/abort outside WAIT must not produce a response
      @(negedge clk);
      bus.net_done = 1'b1; bus.abort = 1'b1;
      @(negedge clk);
      bus.net_done = 1'b0; bus.abort = 1'b0;
      chk("busy_after_idle_done", 32'(bus.busy), 32'd0);

      // illegal commands
      do_cmd(1, 13, 4, 11, 5);
      do_cmd(0, 22, 1, 0, 7);
      do_cmd(2, 0, 0, 0, 2001);
      do_cmd(0, 3, 2, 0, 300);
      wait_drain();

      do_run(0, 0, 200);

      // reset in the middle of WAIT drops the run silently
      model_cmd(3, 0, 0, 0, 0);
      issue(3, 0, 0, 0, 0);
      repeat (10) @(posedge clk);
      #1 rst_n = 1'b0;
      #1 chk_reset_outputs("midrun_reset");
      model_err = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_reset_release", 32'(bus.cmd_ready), 32'd1);
      wait_drain();

      for (int i = 0; i < 60; i++) begin
         op  = $urandom_range(0, 3);
         nrn = ($urandom_range(0, 5) == 0) ? $urandom_range(22, 31) : $urandom_range(0, 21);
         sub = (op == 1) ? $urandom_range(0, 5) : $urandom_range(0, 15);
         aux = $urandom_range(0, 24);
         dat = (op == 2) ? $urandom_range(0, 2100) : $urandom_range(0, 65535);
         if (op == 3) begin
            lim = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 60);
            d   = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 70);
            a   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 70) : 0;
            if (lim == 0 && d == 0 && a == 0) a = $urandom_range(1, 70);
            do_run(lim, d, a);
         end else begin
            do_cmd(op, nrn, sub, aux, dat);
         end
      end

      wait_drain();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/sn_net_cmd_sequencer.md
Name: sn_net_cmd_sequencer

Overview:
- Hardware sequencer that configures and runs one spiking-neuron network instance from a command stream, replacing bench-only tasks: memory writes, weight loads, period setup, start, and watchdog wait.
- Sits between a host/command FIFO and the network's memory interface and controller ports.
- Generalises the single-write flow with paired weight-row loads, a per-run watchdog with timeout reporting, run-cycle measurement, abort, and sticky error flags.

Parameters:
- P_NUM_NEURONS, 21, neurons in the attached network; valid neuron index range is 1..P_NUM_NEURONS.
- P_TABLE_NUM_ROWS, 4, weight-table rows per neuron.
- P_NEUR_CURRENT_BW, 9, width of the network write data.
- P_MAX_NUM_PERIODS, 2000, maximum evaluation periods; period field width L_PER_BW = $clog2(P_MAX_NUM_PERIODS+1).
- P_WDOG_BW, 16, watchdog/cycle-counter width. Must be >= L_PER_BW and >= P_NEUR_CURRENT_BW.
- Derived: L_MSB_BW = $clog2(P_NUM_NEURONS+1); L_LSB_BW = $clog2(P_TABLE_NUM_ROWS*2+2).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  sequencer accepts a command
- cmd_op  in  2  0 = WRITE, 1 = LOAD_WEIGHT, 2 = SET_PERIODS, 3 = RUN
- cmd_neuron  in  L_MSB_BW  target neuron index
- cmd_sub  in  L_LSB_BW  internal address (WRITE) or row number (LOAD_WEIGHT)
- cmd_aux  in  L_MSB_BW  associated neuron index (LOAD_WEIGHT)
- cmd_data  in  P_WDOG_BW  data, weight, period count, or watchdog limit
- abort  in  1  abandon the current RUN wait
- net_we  out  1  network memory write enable
- net_waddr  out  L_MSB_BW+L_LSB_BW  {neuron, internal address}
- net_wdata  out  P_NEUR_CURRENT_BW  write data
- net_num_per_wen  out  1  period register write enable
- net_num_per_d  out  L_PER_BW  period count
- net_start  out  1  network start pulse
- net_done  in  1  network finished
- rsp_valid  out  1  one-cycle run-complete pulse
- rsp_timeout  out  1  run ended by watchdog or abort
- rsp_cycles  out  P_WDOG_BW  cycles from net_start to completion
- err_cmd  out  1  sticky: an illegal command was dropped
- busy  out  1  state != IDLE

Behaviour:
- Reset (rst low, asynchronous): state goes to IDLE. All outputs are 0 except cmd_ready = 1. Counters and err_cmd clear. Reset asserted mid-run drops the run; no rsp is issued.
- cmd_ready = 1 only in IDLE. A command is accepted on a clock edge where cmd_valid and cmd_ready are both high.
- All network outputs are registered. Each net_* strobe is high for exactly one cycle. Address and data are zero whenever the corresponding enable is low.
- States: IDLE, WR, WT_IDX, WT_VAL, SETP, START, WAIT, RSP.
- WRITE: IDLE -> WR. Drives net_we=1, net_waddr = {cmd_neuron, cmd_sub}, net_wdata = cmd_data[P_NEUR_CURRENT_BW-1:0]. Then -> IDLE.
- LOAD_WEIGHT: IDLE -> WT_IDX, then WT_VAL on consecutive cycles.
  - WT_IDX writes sub = row*2+2, data = cmd_aux (zero-extended).
  - WT_VAL writes sub = row*2+3, data = cmd_data (two's complement, truncated).
  - Then -> IDLE.
- SET_PERIODS: SETP drives net_num_per_wen=1, net_num_per_d = cmd_data[L_PER_BW-1:0]. Then -> IDLE.
- RUN:
  - START asserts net_start and latches limit = cmd_data. The cycle counter resets to 1 on the cycle after START.
  - WAIT increments the counter each cycle, saturating at all-ones. WAIT exits on the first of:
    - net_done -> rsp_timeout=0
    - limit != 0 and counter == limit -> rsp_timeout=1
    - abort -> rsp_timeout=1
  - If net_done coincides with the watchdog limit or abort, done wins (rsp_timeout=0).
  - limit = 0 disables the watchdog.
  - RSP pulses rsp_valid for one cycle. rsp_timeout and rsp_cycles hold until the next RSP. Then -> IDLE.
  - net_done is ignored outside WAIT.
- Illegal commands are dropped (no net strobe, 1-cycle IDLE stay, err_cmd set until reset):
  - cmd_neuron = 0 or > P_NUM_NEURONS (WRITE, LOAD_WEIGHT)
  - LOAD_WEIGHT with cmd_sub >= P_TABLE_NUM_ROWS, or with cmd_aux = 0 or > P_NUM_NEURONS
  - SET_PERIODS with cmd_data = 0 or > P_MAX_NUM_PERIODS
- abort outside WAIT has no effect.

Test Plan:
- Reset, then WRITE neuron 11, sub 1, data 120 -> one cycle later net_we=1, net_waddr={11,1}, net_wdata=120; cmd_ready low for exactly 1 cycle.
- LOAD_WEIGHT neuron 13, row 1, aux 11, data -20 -> two consecutive writes: {13,4}/11, then {13,5}/9'h1EC; err_cmd stays 0.
- SET_PERIODS 1500, RUN limit 10000, model asserts net_done 37 cycles after net_start -> rsp_valid pulse, rsp_timeout=0, rsp_cycles=37.
- RUN limit 50, net_done never asserted -> rsp_timeout=1, rsp_cycles=50; repeat with net_done on cycle 50 -> rsp_timeout=0.
- LOAD_WEIGHT row 4, WRITE neuron 22, SET_PERIODS 2001 -> no net strobes, err_cmd=1; a following legal WRITE still executes.
- RUN limit 0, abort at cycle 200 -> rsp_timeout=1, rsp_cycles=200; separately, rst low during WAIT -> all outputs 0, no rsp_valid, cmd_ready=1 after release.
